// File: rtl/coproc_pkg.sv
// Shared coprocessor definitions: matrix geometry, sequencer command encodings and
// the controller's instruction opcodes.
package coproc_pkg;

    localparam int unsigned ELEM_W  = 8;
    localparam int unsigned DIM_MAX = 5;
    localparam int unsigned MAT_W   = DIM_MAX * DIM_MAX * ELEM_W;

    typedef enum logic [1:0] {
        CmdLoadA  = 2'd0,
        CmdLoadB  = 2'd1,
        CmdStoreC = 2'd2,
        CmdRsvd   = 2'd3
    } cmd_op_e;

    typedef enum logic [3:0] {
        OpRead  = 4'd0,
        OpWrite = 4'd1,
        OpSum   = 4'd2,
        OpSub   = 4'd3,
        OpMul   = 4'd4,
        OpTrans = 4'd5,
        OpDet2  = 4'd6,
        OpDet3  = 4'd7,
        OpDet4  = 4'd8,
        OpDet5  = 4'd9
    } ctrl_op_e;

    function automatic logic dim_legal(input logic [2:0] dim, input int unsigned dim_max);
        return (dim >= 3'd2) && (32'(dim) <= dim_max);
    endfunction

endpackage

// File: rtl/matrix_addr_gen.sv
// Row/column walker for one matrix command: produces the packed row-major memory address
// and the bit offset of the element inside the fixed DIM_MAX x DIM_MAX register slot.
module matrix_addr_gen #(
    parameter int unsigned ELEM_W  = 8,
    parameter int unsigned DIM_MAX = 5,
    parameter int unsigned ADDR_W  = 8,
    localparam int unsigned OffW   = $clog2(DIM_MAX * DIM_MAX * ELEM_W)
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              clear_i,
    input  logic              advance_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic [2:0]        dim_i,
    output logic              last_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [OffW-1:0]   bit_off_o
);

    logic [2:0] row_q, row_d;
    logic [2:0] col_q, col_d;
    logic [5:0] row_span;

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clear_i) begin
            row_d = '0;
            col_d = '0;
        end else if (advance_i) begin
            if (col_q == dim_i - 3'd1) begin
                col_d = '0;
                row_d = row_q + 3'd1;
            end else begin
                col_d = col_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign last_o    = (row_q == dim_i - 3'd1) && (col_q == dim_i - 3'd1);
    assign row_span  = 6'(row_q) * 6'(dim_i);
    // Address arithmetic wraps modulo 2^ADDR_W by construction.
    assign addr_o    = base_i + ADDR_W'(row_span) + ADDR_W'(col_q);
    assign bit_off_o = OffW'((32'(row_q) * DIM_MAX + 32'(col_q)) * ELEM_W);

endmodule

// File: rtl/matrix_mem_sequencer.sv
// Executes LOAD_A / LOAD_B / STORE_C commands as a sequence of single-element
// start/done memory transactions between byte memory and the matrix registers.
module matrix_mem_sequencer
    import coproc_pkg::*;
#(
    parameter int unsigned ELEM_W  = 8,
    parameter int unsigned DIM_MAX = 5,
    parameter int unsigned ADDR_W  = 8,
    localparam int unsigned MatW   = DIM_MAX * DIM_MAX * ELEM_W,
    localparam int unsigned OffW   = $clog2(MatW)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_base,
    input  logic [2:0]        cmd_dim,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [ELEM_W-1:0] mem_wdata,
    output logic              mem_wr,
    output logic              mem_start,
    input  logic [ELEM_W-1:0] mem_rdata,
    input  logic              mem_done,
    input  logic [MatW-1:0]   matrix_c,
    output logic [MatW-1:0]   matrix_a,
    output logic [MatW-1:0]   matrix_b,
    output logic              busy,
    output logic              cmd_done,
    output logic              cmd_err
);

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StNext,
        StFinish,
        StErrWait,
        StErr
    } state_e;

    state_e            state_q, state_d;
    cmd_op_e           op_q;
    cmd_op_e           op_in;
    logic [ADDR_W-1:0] base_q;
    logic [2:0]        dim_q;
    logic [MatW-1:0]   mat_a_q, mat_b_q;

    logic              accept;
    logic              zero_a, zero_b;
    logic              capture;
    logic              ag_clear, ag_advance, ag_last;
    logic [ADDR_W-1:0] ag_addr;
    logic [OffW-1:0]   ag_off;

    assign op_in = cmd_op_e'(cmd_op);

    matrix_addr_gen #(
        .ELEM_W  (ELEM_W),
        .DIM_MAX (DIM_MAX),
        .ADDR_W  (ADDR_W)
    ) u_addr_gen (
        .clk_i     (clk),
        .reset_i   (reset),
        .clear_i   (ag_clear),
        .advance_i (ag_advance),
        .base_i    (base_q),
        .dim_i     (dim_q),
        .last_o    (ag_last),
        .addr_o    (ag_addr),
        .bit_off_o (ag_off)
    );

    always_comb begin
        state_d    = state_q;
        cmd_ready  = 1'b0;
        busy       = 1'b1;
        mem_start  = 1'b0;
        cmd_done   = 1'b0;
        cmd_err    = 1'b0;
        accept     = 1'b0;
        zero_a     = 1'b0;
        zero_b     = 1'b0;
        capture    = 1'b0;
        ag_clear   = 1'b0;
        ag_advance = 1'b0;
        unique case (state_q)
            StIdle: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                ag_clear  = 1'b1;
                if (cmd_valid) begin
                    accept = 1'b1;
                    if (op_in == CmdRsvd || !dim_legal(cmd_dim, DIM_MAX)) begin
                        state_d = StErrWait;
                    end else begin
                        zero_a  = (op_in == CmdLoadA);
                        zero_b  = (op_in == CmdLoadB);
                        state_d = StIssue;
                    end
                end
            end
            StIssue: begin
                mem_start = 1'b1;
                if (mem_done) begin
                    capture = (op_q != CmdStoreC);
                    state_d = StNext;
                end
            end
            StNext: begin
                if (ag_last) begin
                    state_d = StFinish;
                end else begin
                    ag_advance = 1'b1;
                    state_d    = StIssue;
                end
            end
            StFinish: begin
                cmd_done = 1'b1;
                state_d  = StIdle;
            end
            // Illegal commands take one quiet cycle before reporting.
            StErrWait: state_d = StErr;
            StErr: begin
                cmd_done = 1'b1;
                cmd_err  = 1'b1;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            op_q    <= CmdLoadA;
            base_q  <= '0;
            dim_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q   <= op_in;
                base_q <= cmd_base;
                dim_q  <= cmd_dim;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mat_a_q <= '0;
        end else if (zero_a) begin
            mat_a_q <= '0;
        end else if (capture && op_q == CmdLoadA) begin
            mat_a_q[ag_off +: ELEM_W] <= mem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mat_b_q <= '0;
        end else if (zero_b) begin
            mat_b_q <= '0;
        end else if (capture && op_q == CmdLoadB) begin
            mat_b_q[ag_off +: ELEM_W] <= mem_rdata;
        end
    end

    assign matrix_a  = mat_a_q;
    assign matrix_b  = mat_b_q;
    assign mem_addr  = mem_start ? ag_addr : '0;
    assign mem_wr    = mem_start && (op_q == CmdStoreC);
    assign mem_wdata = mem_wr ? matrix_c[ag_off +: ELEM_W] : '0;

endmodule

// File: tb/tb_matrix_mem_sequencer.sv
// Self-checking bench for matrix_mem_sequencer: memory model with configurable/random
// latency and a transaction scoreboard.
module tb_matrix_mem_sequencer;

    typedef struct packed {
        logic [7:0] addr;
        logic       wr;
        logic [7:0] data;
    } txn_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         cmd_valid = 1'b0;
    logic [1:0]   cmd_op = '0;
    logic [7:0]   cmd_base = '0;
    logic [2:0]   cmd_dim = '0;
    logic         cmd_ready;
    logic [7:0]   mem_addr, mem_wdata, mem_rdata;
    logic         mem_wr, mem_start, mem_done;
    logic [199:0] matrix_c = '0;
    logic [199:0] matrix_a, matrix_b;
    logic         busy, cmd_done, cmd_err;

    logic [7:0]   mem [256];
    txn_t         exp_q[$];
    txn_t         obs_q[$];
    int           checks = 0;
    int           errors = 0;
    int           k_mode = 0;
    int           k_rand = 0;
    int           cnt = 0;
    int           start_cnt = 0;
    int           kk;
    logic         stray_done = 1'b0;

    always #5 clk = ~clk;

    matrix_mem_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_base  (cmd_base),
        .cmd_dim   (cmd_dim),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wr    (mem_wr),
        .mem_start (mem_start),
        .mem_rdata (mem_rdata),
        .mem_done  (mem_done),
        .matrix_c  (matrix_c),
        .matrix_a  (matrix_a),
        .matrix_b  (matrix_b),
        .busy      (busy),
        .cmd_done  (cmd_done),
        .cmd_err   (cmd_err)
    );

    // Memory model: done arrives kk cycles after start rises.
    always_comb kk = (k_mode >= 0) ? k_mode : k_rand;
    assign mem_done  = (mem_start && (cnt == kk)) || stray_done;
    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (!reset && mem_start && mem_done) begin
            obs_q.push_back('{addr: mem_addr, wr: mem_wr, data: mem_wdata});
            if (mem_wr) mem[mem_addr] = mem_wdata;
            k_rand <= int'($urandom_range(0, 3));
        end
        if (mem_start) start_cnt <= start_cnt + 1;
        cnt <= (mem_start && !mem_done) ? cnt + 1 : 0;
    end

    task automatic run_cmd(input logic [1:0] op, input logic [7:0] base, input logic [2:0] dim,
                           output int lat, output logic err);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_base  = base;
        cmd_dim   = dim;
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 1;
        while (cmd_done !== 1'b1 && lat < 1000) begin
            @(negedge clk);
            lat++;
        end
        err = cmd_err;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({cmd_ready, busy, cmd_done, cmd_err, mem_start, mem_wr} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 100000",
                     {cmd_ready, busy, cmd_done, cmd_err, mem_start, mem_wr});
        end
        checks++;
        if (matrix_a !== '0 || matrix_b !== '0 || mem_addr !== '0 || mem_wdata !== '0) begin
            errors++;
            $display("FAIL reset_data: a=%h b=%h addr=%h wdata=%h want all 0",
                     matrix_a, matrix_b, mem_addr, mem_wdata);
        end
        reset = 1'b0;
    endtask

    task automatic test_load_a_small(output logic [199:0] exp_a);
        int lat;
        logic err;
        k_mode = 0;
        exp_a = '0;
        exp_q.delete();
        obs_q.delete();
        for (int i = 0; i < 4; i++) begin
            mem[8'h10 + 8'(i)] = 8'(i + 1);
            exp_q.push_back('{addr: 8'h10 + 8'(i), wr: 1'b0, data: 8'h00});
        end
        exp_a[0*8 +: 8] = 8'd1;
        exp_a[1*8 +: 8] = 8'd2;
        exp_a[5*8 +: 8] = 8'd3;
        exp_a[6*8 +: 8] = 8'd4;
        run_cmd(2'd0, 8'h10, 3'd2, lat, err);
        checks++;
        if (lat !== 9) begin errors++; $display("FAIL load_a_latency: got %0d want 9", lat); end
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL load_a_err: got %b want 0", err); end
        checks++;
        if (matrix_a !== exp_a) begin
            errors++;
            $display("FAIL load_a_data: got %h want %h", matrix_a, exp_a);
        end
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL load_a_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            txn_t o = obs_q.pop_front();
            txn_t e = exp_q.pop_front();
            checks++;
            if (o.addr !== e.addr || o.wr !== e.wr) begin
                errors++;
                $display("FAIL load_a_txn: got addr=%h wr=%b want addr=%h wr=%b",
                         o.addr, o.wr, e.addr, e.wr);
            end
        end
    endtask

    task automatic test_load_b_wrap(input logic [199:0] prev_a);
        int lat;
        logic err;
        logic [199:0] exp_b = '0;
        k_mode = 1;
        exp_q.delete();
        obs_q.delete();
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) begin
                logic [7:0] a = 8'hF0 + 8'(r * 5 + c);
                mem[a] = 8'(8'h21 + r * 5 + c);
                exp_b[(r * 5 + c) * 8 +: 8] = 8'(8'h21 + r * 5 + c);
                exp_q.push_back('{addr: a, wr: 1'b0, data: 8'h00});
            end
        end
        run_cmd(2'd1, 8'hF0, 3'd5, lat, err);
        checks++;
        if (lat !== 76) begin errors++; $display("FAIL load_b_latency: got %0d want 76", lat); end
        checks++;
        if (matrix_b !== exp_b) begin
            errors++;
            $display("FAIL load_b_data: got %h want %h", matrix_b, exp_b);
        end
        checks++;
        if (matrix_a !== prev_a) begin
            errors++;
            $display("FAIL load_b_a_kept: got %h want %h", matrix_a, prev_a);
        end
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL load_b_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            txn_t o = obs_q.pop_front();
            txn_t e = exp_q.pop_front();
            checks++;
            if (o.addr !== e.addr || o.wr !== e.wr) begin
                errors++;
                $display("FAIL load_b_txn: got addr=%h wr=%b want addr=%h wr=%b",
                         o.addr, o.wr, e.addr, e.wr);
            end
        end
    endtask

    task automatic test_store_c();
        int lat;
        logic err;
        k_mode = -1;
        exp_q.delete();
        obs_q.delete();
        for (int i = 0; i < 25; i++) matrix_c[i * 8 +: 8] = 8'hEE;
        for (int i = 0; i < 9; i++) mem[8'h40 + 8'(i)] = 8'h00;
        mem[8'h49] = 8'h5A;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                matrix_c[(r * 5 + c) * 8 +: 8] = 8'(r * 10 + c);
                exp_q.push_back('{addr: 8'h40 + 8'(3 * r + c), wr: 1'b1, data: 8'(r * 10 + c)});
            end
        end
        run_cmd(2'd2, 8'h40, 3'd3, lat, err);
        checks++;
        if (lat >= 1000 || err !== 1'b0) begin
            errors++;
            $display("FAIL store_c_done: got lat=%0d err=%b want done with err 0", lat, err);
        end
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL store_c_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            txn_t o = obs_q.pop_front();
            txn_t e = exp_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL store_c_txn: got %h/%b/%h want %h/%b/%h",
                         o.addr, o.wr, o.data, e.addr, e.wr, e.data);
            end
        end
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                checks++;
                if (mem[8'h40 + 8'(3 * r + c)] !== 8'(r * 10 + c)) begin
                    errors++;
                    $display("FAIL store_c_mem: addr %h got %h want %h", 8'h40 + 8'(3 * r + c),
                             mem[8'h40 + 8'(3 * r + c)], 8'(r * 10 + c));
                end
            end
        end
        checks++;
        if (mem[8'h49] !== 8'h5A) begin
            errors++;
            $display("FAIL store_c_untouched: got %h want 5a", mem[8'h49]);
        end
    endtask

    task automatic test_illegal();
        logic [1:0] ops [3];
        logic [2:0] dims [3];
        ops[0] = 2'd0; dims[0] = 3'd1;
        ops[1] = 2'd1; dims[1] = 3'd6;
        ops[2] = 2'd3; dims[2] = 3'd3;
        for (int i = 0; i < 3; i++) begin
            int lat;
            logic err;
            logic [199:0] a0 = matrix_a;
            logic [199:0] b0 = matrix_b;
            int s0 = start_cnt;
            run_cmd(ops[i], 8'h20, dims[i], lat, err);
            checks++;
            if (lat !== 2 || err !== 1'b1) begin
                errors++;
                $display("FAIL illegal_%0d_pulse: got lat=%0d err=%b want lat=2 err=1", i, lat, err);
            end
            checks++;
            if (start_cnt !== s0) begin
                errors++;
                $display("FAIL illegal_%0d_mem: got %0d start cycles want 0", i, start_cnt - s0);
            end
            checks++;
            if (matrix_a !== a0 || matrix_b !== b0) begin
                errors++;
                $display("FAIL illegal_%0d_regs: a=%h b=%h changed", i, matrix_a, matrix_b);
            end
        end
    endtask

    task automatic test_reset_mid();
        int issues = 0;
        int bound = 0;
        logic bad_ready = 1'b0;
        logic done_seen = 1'b0;
        logic [199:0] exp_mid = '0;
        k_mode = 0;
        for (int i = 0; i < 9; i++) mem[8'(i)] = 8'(8'h31 + i);
        exp_mid[0 * 8 +: 8] = 8'h31;
        exp_mid[1 * 8 +: 8] = 8'h32;
        exp_mid[2 * 8 +: 8] = 8'h33;
        exp_mid[5 * 8 +: 8] = 8'h34;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 2'd0;
        cmd_base  = 8'h00;
        cmd_dim   = 3'd3;
        while (issues < 5 && bound < 100) begin
            @(negedge clk);
            bound++;
            if (busy && cmd_ready) bad_ready = 1'b1;
            if (cmd_done) done_seen = 1'b1;
            if (mem_start) issues++;
        end
        checks++;
        if (issues !== 5 || matrix_a !== exp_mid) begin
            errors++;
            $display("FAIL mid_progress: got issues=%0d a=%h want 5 and %h", issues, matrix_a,
                     exp_mid);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({mem_start, cmd_ready, busy, cmd_done} !== 4'b0100) begin
            errors++;
            $display("FAIL mid_reset_ctrl: got %b want 0100", {mem_start, cmd_ready, busy, cmd_done});
        end
        checks++;
        if (matrix_a !== '0) begin
            errors++;
            $display("FAIL mid_reset_a: got %h want 0", matrix_a);
        end
        checks++;
        if (bad_ready !== 1'b0 || done_seen !== 1'b0) begin
            errors++;
            $display("FAIL mid_no_accept: got ready_while_busy=%b done=%b want 0 0", bad_ready,
                     done_seen);
        end
        cmd_valid = 1'b0;
        reset = 1'b0;
        obs_q.delete();
    endtask

    task automatic test_back_to_back();
        int lat = 1;
        logic [199:0] exp_a = '0;
        logic [7:0] src [16];
        k_mode = -1;
        exp_q.delete();
        obs_q.delete();
        for (int i = 0; i < 16; i++) begin
            src[i] = 8'(i * 17 - 100);
            mem[8'h80 + 8'(i)] = src[i];
            mem[8'hA0 + 8'(i)] = 8'h00;
            exp_a[((i / 4) * 5 + (i % 4)) * 8 +: 8] = src[i];
            exp_q.push_back('{addr: 8'h80 + 8'(i), wr: 1'b0, data: 8'h00});
        end
        for (int i = 0; i < 16; i++) exp_q.push_back('{addr: 8'hA0 + 8'(i), wr: 1'b1, data: src[i]});
        @(negedge clk);
        stray_done = 1'b1;
        @(negedge clk);
        stray_done = 1'b0;
        checks++;
        if (busy !== 1'b0 || obs_q.size() !== 0) begin
            errors++;
            $display("FAIL stray_idle: got busy=%b txns=%0d want 0 0", busy, obs_q.size());
        end
        cmd_valid = 1'b1;
        cmd_op    = 2'd0;
        cmd_base  = 8'h80;
        cmd_dim   = 3'd4;
        @(negedge clk);
        cmd_valid = 1'b0;
        while (cmd_done !== 1'b1 && lat < 1000) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat >= 1000 || matrix_a !== exp_a) begin
            errors++;
            $display("FAIL b2b_load: got lat=%0d a=%h want done and %h", lat, matrix_a, exp_a);
        end
        matrix_c   = exp_a;
        cmd_valid  = 1'b1;
        cmd_op     = 2'd2;
        cmd_base   = 8'hA0;
        stray_done = 1'b1;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_ready: got ready=%b busy=%b want 1 0", cmd_ready, busy);
        end
        @(negedge clk);
        cmd_valid  = 1'b0;
        stray_done = 1'b0;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: got busy=%b want 1", busy); end
        lat = 1;
        while (cmd_done !== 1'b1 && lat < 1000) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat >= 1000 || cmd_err !== 1'b0) begin
            errors++;
            $display("FAIL b2b_store_done: got lat=%0d err=%b", lat, cmd_err);
        end
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL b2b_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            txn_t o = obs_q.pop_front();
            txn_t e = exp_q.pop_front();
            checks++;
            if (o.addr !== e.addr || o.wr !== e.wr || (e.wr && o.data !== e.data)) begin
                errors++;
                $display("FAIL b2b_txn: got %h/%b/%h want %h/%b/%h",
                         o.addr, o.wr, o.data, e.addr, e.wr, e.data);
            end
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (mem[8'hA0 + 8'(i)] !== src[i]) begin
                errors++;
                $display("FAIL b2b_roundtrip: addr %h got %h want %h", 8'hA0 + 8'(i),
                         mem[8'hA0 + 8'(i)], src[i]);
            end
        end
    endtask

    initial begin
        logic [199:0] a_after;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        test_reset();
        test_load_a_small(a_after);
        test_load_b_wrap(a_after);
        test_store_c();
        test_illegal();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
